// File: rtl/load_store_queue.sv
// Circular load/store queue: in-order allocate and retire, with address and
// value fields filled out of order by ROB-id match.
module load_store_queue #(
  parameter int DEPTH = 8,
  parameter int XLEN  = 64,
  parameter int ROBW  = 5
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         flush,
  input  logic                         alloc_valid,
  input  logic                         alloc_is_load,
  input  logic [XLEN-1:0]              alloc_pc,
  input  logic [ROBW-1:0]              alloc_rob_id,
  output logic                         alloc_ready,
  input  logic                         addr_wr,
  input  logic [ROBW-1:0]              addr_rob_id,
  input  logic [XLEN-1:0]              addr_in,
  input  logic                         val_wr,
  input  logic [ROBW-1:0]              val_rob_id,
  input  logic [XLEN-1:0]              val_in,
  output logic                         head_valid,
  output logic                         head_is_load,
  output logic [XLEN-1:0]              head_pc,
  output logic [ROBW-1:0]              head_rob_id,
  output logic                         head_addr_valid,
  output logic [XLEN-1:0]              head_addr,
  output logic                         head_val_valid,
  output logic [XLEN-1:0]              head_val,
  output logic                         head_ready,
  input  logic                         retire,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int PTRW = $clog2(DEPTH);
  localparam int CNTW = $clog2(DEPTH+1);

  logic [PTRW-1:0]  r_head_ptr;
  logic [PTRW-1:0]  r_tail_ptr;
  logic [CNTW-1:0]  r_count;

  logic [DEPTH-1:0] r_valid;
  logic [DEPTH-1:0] r_addr_valid;
  logic [DEPTH-1:0] r_val_valid;
  logic [DEPTH-1:0] r_is_load;
  logic [XLEN-1:0]  r_pc     [DEPTH];
  logic [ROBW-1:0]  r_rob_id [DEPTH];
  logic [XLEN-1:0]  r_addr   [DEPTH];
  logic [XLEN-1:0]  r_val    [DEPTH];

  logic             w_full;
  logic             w_head_valid;
  logic             w_head_ready;
  logic             w_do_alloc;
  logic             w_do_retire;
  logic [DEPTH-1:0] w_alloc_sel;
  logic [DEPTH-1:0] w_retire_sel;
  logic [DEPTH-1:0] w_addr_hit;
  logic [DEPTH-1:0] w_val_hit;

  assign w_full       = (r_count == CNTW'(DEPTH));
  assign w_head_valid = (r_count != '0);
  assign w_head_ready = w_head_valid && r_addr_valid[r_head_ptr] && r_val_valid[r_head_ptr];

  // Flush wins over every other request in its cycle, so it gates them all here.
  assign w_do_alloc  = alloc_valid && !w_full && !flush;
  assign w_do_retire = retire && w_head_ready && !flush;

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    w_alloc_sel  = '0;
    w_retire_sel = '0;
    w_addr_hit   = '0;
    w_val_hit    = '0;
    for (int i = 0; i < DEPTH; i++) begin
      w_alloc_sel[i]  = w_do_alloc  && (r_tail_ptr == PTRW'(i));
      w_retire_sel[i] = w_do_retire && (r_head_ptr == PTRW'(i));
      // Matching only already-valid entries keeps a same-cycle allocation out of reach.
      w_addr_hit[i]   = addr_wr && !flush && r_valid[i] && (r_rob_id[i] == addr_rob_id);
      w_val_hit[i]    = val_wr  && !flush && r_valid[i] && (r_rob_id[i] == val_rob_id);
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers see pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_head_ptr <= '0;
      r_tail_ptr <= '0;
      r_count    <= '0;
    end else if (flush) begin
      r_head_ptr <= '0;
      r_tail_ptr <= '0;
      r_count    <= '0;
    end else begin
      if (w_do_alloc)  r_tail_ptr <= r_tail_ptr + PTRW'(1);
      if (w_do_retire) r_head_ptr <= r_head_ptr + PTRW'(1);
      case ({w_do_alloc, w_do_retire})
        2'b10:   r_count <= r_count + CNTW'(1);
        2'b01:   r_count <= r_count - CNTW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_valid      <= '0;
      r_addr_valid <= '0;
      r_val_valid  <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (flush) begin
          r_valid[i] <= 1'b0;
        end else if (w_alloc_sel[i]) begin
          r_valid[i]      <= 1'b1;
          r_addr_valid[i] <= 1'b0;
          r_val_valid[i]  <= 1'b0;
        end else begin
          if (w_retire_sel[i]) r_valid[i]      <= 1'b0;
          if (w_addr_hit[i])   r_addr_valid[i] <= 1'b1;
          if (w_val_hit[i])    r_val_valid[i]  <= 1'b1;
        end
      end
    end
  end

  // NOTE: payload storage has no reset; it is only observed through a set valid bit.
  always_ff @(posedge clk) begin
    for (int i = 0; i < DEPTH; i++) begin
      if (w_alloc_sel[i]) begin
        r_is_load[i] <= alloc_is_load;
        r_pc[i]      <= alloc_pc;
        r_rob_id[i]  <= alloc_rob_id;
        r_addr[i]    <= '0;
        r_val[i]     <= '0;
      end else begin
        if (w_addr_hit[i]) r_addr[i] <= addr_in;
        if (w_val_hit[i])  r_val[i]  <= val_in;
      end
    end
  end

  assign alloc_ready     = !w_full;
  assign count           = r_count;
  assign head_valid      = w_head_valid;
  assign head_ready      = w_head_ready;
  assign head_is_load    = w_head_valid && r_is_load[r_head_ptr];
  assign head_addr_valid = w_head_valid && r_addr_valid[r_head_ptr];
  assign head_val_valid  = w_head_valid && r_val_valid[r_head_ptr];
  assign head_pc         = w_head_valid ? r_pc[r_head_ptr]     : '0;
  assign head_rob_id     = w_head_valid ? r_rob_id[r_head_ptr] : '0;
  assign head_addr       = w_head_valid ? r_addr[r_head_ptr]   : '0;
  assign head_val        = w_head_valid ? r_val[r_head_ptr]    : '0;

endmodule

// File: tb/tb_load_store_queue.sv
// Bench for load_store_queue: directed vector table, hand-written corner
// sequences, then random traffic against a queue-based reference model.
module tb_load_store_queue;

  localparam int DEPTH = 8;
  localparam int XLEN  = 64;
  localparam int ROBW  = 5;

  logic            clk = 1'b0;
  logic            reset, flush;
  logic            alloc_valid, alloc_is_load;
  logic [XLEN-1:0] alloc_pc;
  logic [ROBW-1:0] alloc_rob_id;
  logic            alloc_ready;
  logic            addr_wr;
  logic [ROBW-1:0] addr_rob_id;
  logic [XLEN-1:0] addr_in;
  logic            val_wr;
  logic [ROBW-1:0] val_rob_id;
  logic [XLEN-1:0] val_in;
  logic            head_valid, head_is_load, head_addr_valid, head_val_valid, head_ready;
  logic [XLEN-1:0] head_pc, head_addr, head_val;
  logic [ROBW-1:0] head_rob_id;
  logic            retire;
  logic [3:0]      count;

  int n_checks = 0;
  int n_fail   = 0;

  load_store_queue #(.DEPTH(DEPTH), .XLEN(XLEN), .ROBW(ROBW)) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .alloc_valid(alloc_valid), .alloc_is_load(alloc_is_load), .alloc_pc(alloc_pc),
    .alloc_rob_id(alloc_rob_id), .alloc_ready(alloc_ready),
    .addr_wr(addr_wr), .addr_rob_id(addr_rob_id), .addr_in(addr_in),
    .val_wr(val_wr), .val_rob_id(val_rob_id), .val_in(val_in),
    .head_valid(head_valid), .head_is_load(head_is_load), .head_pc(head_pc),
    .head_rob_id(head_rob_id), .head_addr_valid(head_addr_valid), .head_addr(head_addr),
    .head_val_valid(head_val_valid), .head_val(head_val), .head_ready(head_ready),
    .retire(retire), .count(count)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic clr_in();
    flush = 0; alloc_valid = 0; alloc_is_load = 0; alloc_pc = '0; alloc_rob_id = '0;
    addr_wr = 0; addr_rob_id = '0; addr_in = '0;
    val_wr = 0; val_rob_id = '0; val_in = '0; retire = 0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  task automatic alloc_one(input logic il, input logic [63:0] pc, input logic [4:0] rob);
    alloc_valid = 1; alloc_is_load = il; alloc_pc = pc; alloc_rob_id = rob;
    tick();
    clr_in();
  endtask

  // Directed vector table: inputs applied for one cycle, expectations checked after the edge.
  typedef struct {
    logic av; logic il; logic [63:0] pc; logic [4:0] rob;
    logic aw; logic [4:0] arob; logic [63:0] addr;
    logic vw; logic [4:0] vrob; logic [63:0] val;
    logic ret; logic fl;
    logic [3:0] e_cnt; logic e_hv; logic e_hr; logic e_il; logic [4:0] e_rob;
    logic [63:0] e_pc; logic [63:0] e_addr; logic [63:0] e_val; logic e_ar;
  } vec_t;

  vec_t vecs[15];

  // Reference model: a plain queue of entries, oldest first.
  typedef struct {
    logic il; logic [63:0] pc; logic [4:0] rob;
    logic av; logic [63:0] addr; logic vv; logic [63:0] val;
  } ent_t;

  ent_t q[$];

  function automatic logic [4:0] pick_free_rob();
    logic [4:0] r;
    bit used;
    r = 5'($urandom_range(0, 31));
    forever begin
      used = 0;
      foreach (q[k]) if (q[k].rob == r) used = 1;
      if (!used) return r;
      r = r + 5'd1;
    end
  endfunction

  task automatic model_step();
    bit   full, hr;
    ent_t e;
    if (flush) begin
      q.delete();
      return;
    end
    full = (q.size() == DEPTH);
    hr   = (q.size() > 0) && q[0].av && q[0].vv;
    foreach (q[k]) begin
      if (addr_wr && q[k].rob == addr_rob_id) begin q[k].av = 1; q[k].addr = addr_in; end
      if (val_wr  && q[k].rob == val_rob_id)  begin q[k].vv = 1; q[k].val  = val_in;  end
    end
    if (retire && hr) void'(q.pop_front());
    if (alloc_valid && !full) begin
      e = '{alloc_is_load, alloc_pc, alloc_rob_id, 1'b0, 64'h0, 1'b0, 64'h0};
      q.push_back(e);
    end
  endtask

  task automatic model_compare();
    bit   hv;
    ent_t h;
    hv = (q.size() > 0);
    h  = hv ? q[0] : '{1'b0, 64'h0, 5'h0, 1'b0, 64'h0, 1'b0, 64'h0};
    check("rnd count",       count, q.size());
    check("rnd alloc_ready", alloc_ready, q.size() != DEPTH);
    check("rnd head_valid",  head_valid, hv);
    check("rnd head_ready",  head_ready, hv && h.av && h.vv);
    check("rnd head_is_load", head_is_load, h.il);
    check("rnd head_pc",     head_pc, h.pc);
    check("rnd head_rob_id", head_rob_id, h.rob);
    check("rnd head_addr_valid", head_addr_valid, h.av);
    check("rnd head_addr",   head_addr, h.addr);
    check("rnd head_val_valid", head_val_valid, h.vv);
    check("rnd head_val",    head_val, h.val);
  endtask

  initial begin
    //         av il pc      rob aw arob addr     vw vrob val      ret fl | cnt hv hr il rob pc      addr     val      ar
    vecs[0]  = '{1, 1, 'h100, 3, 0, 0, 0,       0, 0, 0,       0, 0,   1, 1, 0, 1, 3, 'h100, 0,       0,       1};
    vecs[1]  = '{0, 0, 0,     0, 1, 3, 'h2000,  1, 3, 'hDEAD,  0, 0,   1, 1, 1, 1, 3, 'h100, 'h2000,  'hDEAD,  1};
    vecs[2]  = '{0, 0, 0,     0, 0, 0, 0,       0, 0, 0,       1, 0,   0, 0, 0, 0, 0, 0,     0,       0,       1};
    vecs[3]  = '{1, 0, 'h200, 1, 0, 0, 0,       0, 0, 0,       0, 0,   1, 1, 0, 0, 1, 'h200, 0,       0,       1};
    vecs[4]  = '{1, 0, 'h204, 2, 0, 0, 0,       0, 0, 0,       0, 0,   2, 1, 0, 0, 1, 'h200, 0,       0,       1};
    vecs[5]  = '{1, 0, 'h208, 3, 1, 3, 'hAAAA,  1, 3, 'hBBBB,  0, 0,   3, 1, 0, 0, 1, 'h200, 0,       0,       1};
    vecs[6]  = '{0, 0, 0,     0, 1, 2, 'h3333,  1, 2, 'h4444,  0, 0,   3, 1, 0, 0, 1, 'h200, 0,       0,       1};
    vecs[7]  = '{0, 0, 0,     0, 0, 0, 0,       0, 0, 0,       1, 0,   3, 1, 0, 0, 1, 'h200, 0,       0,       1};
    vecs[8]  = '{0, 0, 0,     0, 1, 1, 'h1111,  1, 9, 'h9999,  0, 0,   3, 1, 0, 0, 1, 'h200, 'h1111,  0,       1};
    vecs[9]  = '{0, 0, 0,     0, 0, 0, 0,       1, 1, 'h2222,  0, 0,   3, 1, 1, 0, 1, 'h200, 'h1111,  'h2222,  1};
    vecs[10] = '{0, 0, 0,     0, 0, 0, 0,       0, 0, 0,       1, 0,   2, 1, 1, 0, 2, 'h204, 'h3333,  'h4444,  1};
    vecs[11] = '{0, 0, 0,     0, 0, 0, 0,       0, 0, 0,       1, 0,   1, 1, 0, 0, 3, 'h208, 0,       0,       1};
    vecs[12] = '{0, 0, 0,     0, 1, 3, 'h5555,  1, 3, 'h6666,  0, 0,   1, 1, 1, 0, 3, 'h208, 'h5555,  'h6666,  1};
    vecs[13] = '{1, 1, 'h300, 4, 0, 0, 0,       0, 0, 0,       1, 0,   1, 1, 0, 1, 4, 'h300, 0,       0,       1};
    vecs[14] = '{1, 0, 'h400, 5, 1, 4, 'h7777,  0, 0, 0,       1, 1,   0, 0, 0, 0, 0, 0,     0,       0,       1};

    clr_in();
    reset = 1'b1;
    #3;
    check("reset count", count, 0);
    check("reset alloc_ready", alloc_ready, 1);
    check("reset head_valid", head_valid, 0);
    check("reset head_ready", head_ready, 0);
    check("reset head_pc", head_pc, 0);
    tick();
    reset = 1'b0;

    // Directed table
    for (int v = 0; v < 15; v++) begin
      alloc_valid = vecs[v].av; alloc_is_load = vecs[v].il; alloc_pc = vecs[v].pc;
      alloc_rob_id = vecs[v].rob; addr_wr = vecs[v].aw; addr_rob_id = vecs[v].arob;
      addr_in = vecs[v].addr; val_wr = vecs[v].vw; val_rob_id = vecs[v].vrob;
      val_in = vecs[v].val; retire = vecs[v].ret; flush = vecs[v].fl;
      tick();
      check($sformatf("vec%0d count", v), count, vecs[v].e_cnt);
      check($sformatf("vec%0d head_valid", v), head_valid, vecs[v].e_hv);
      check($sformatf("vec%0d head_ready", v), head_ready, vecs[v].e_hr);
      check($sformatf("vec%0d head_is_load", v), head_is_load, vecs[v].e_il);
      check($sformatf("vec%0d head_rob_id", v), head_rob_id, vecs[v].e_rob);
      check($sformatf("vec%0d head_pc", v), head_pc, vecs[v].e_pc);
      check($sformatf("vec%0d head_addr", v), head_addr, vecs[v].e_addr);
      check($sformatf("vec%0d head_val", v), head_val, vecs[v].e_val);
      check($sformatf("vec%0d alloc_ready", v), alloc_ready, vecs[v].e_ar);
    end
    clr_in();

    // Fill to full, blocked allocs, drain in order, wrap around
    do_reset();
    for (int i = 0; i < DEPTH; i++) alloc_one(1'b0, 64'h400 + 64'(i * 4), 5'(i));
    check("full count", count, DEPTH);
    check("full alloc_ready", alloc_ready, 0);
    alloc_one(1'b0, 64'h500, 5'd8);
    check("9th alloc count", count, DEPTH);
    check("9th alloc head_rob", head_rob_id, 0);
    for (int i = 0; i < DEPTH; i++) begin
      addr_wr = 1; addr_rob_id = 5'(i); addr_in = 64'(i);
      val_wr = 1; val_rob_id = 5'(i); val_in = 64'(i + 100);
      tick();
    end
    clr_in();
    check("full head_ready", head_ready, 1);
    alloc_valid = 1; alloc_rob_id = 5'd9; alloc_pc = 64'h600; retire = 1;
    tick();
    clr_in();
    check("full alloc+retire count", count, DEPTH - 1);
    check("full alloc+retire head_rob", head_rob_id, 1);
    for (int i = 1; i < DEPTH; i++) begin
      check($sformatf("drain order %0d", i), head_rob_id, i);
      check($sformatf("drain val %0d", i), head_val, i + 100);
      retire = 1;
      tick();
    end
    clr_in();
    check("drained count", count, 0);
    for (int i = 10; i < 13; i++) alloc_one(1'b1, 64'h700 + 64'(i), 5'(i));
    check("wrap count", count, 3);
    check("wrap head_rob", head_rob_id, 10);
    check("wrap head_pc", head_pc, 64'h70a);
    addr_wr = 1; addr_rob_id = 5'd10; val_wr = 1; val_rob_id = 5'd10;
    tick();
    retire = 1; addr_wr = 0; val_wr = 0;
    tick();
    clr_in();
    check("wrap next head_rob", head_rob_id, 11);

    // Asynchronous reset between edges with 5 entries held
    for (int i = 13; i < 16; i++) alloc_one(1'b0, 64'h800, 5'(i));
    check("pre-reset count", count, 5);
    @(negedge clk);
    #2 reset = 1'b1;
    #1;
    check("async reset count", count, 0);
    check("async reset head_valid", head_valid, 0);
    check("async reset alloc_ready", alloc_ready, 1);
    check("async reset head_rob", head_rob_id, 0);
    @(negedge clk);
    reset = 1'b0;

    // Randomized traffic against the reference model
    q.delete();
    for (int c = 0; c < 3000; c++) begin
      alloc_valid   = ($urandom_range(0, 2) != 0);
      alloc_is_load = 1'($urandom_range(0, 1));
      alloc_pc      = {32'($urandom), 32'($urandom)};
      alloc_rob_id  = pick_free_rob();
      addr_wr       = 1'($urandom_range(0, 1));
      addr_rob_id   = (q.size() > 0 && $urandom_range(0, 3) != 0) ?
                      q[$urandom_range(0, q.size() - 1)].rob : 5'($urandom_range(0, 31));
      addr_in       = {32'($urandom), 32'($urandom)};
      val_wr        = 1'($urandom_range(0, 1));
      val_rob_id    = (q.size() > 0 && $urandom_range(0, 3) != 0) ?
                      q[$urandom_range(0, q.size() - 1)].rob : 5'($urandom_range(0, 31));
      val_in        = {32'($urandom), 32'($urandom)};
      retire        = 1'($urandom_range(0, 1));
      flush         = ($urandom_range(0, 79) == 0);
      model_step();
      tick();
      model_compare();
    end
    clr_in();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
